// File: rtl/usb_midi_pio_pkg.sv
// Shared constants and types for the pulse-capable output PIO:
// register word addresses, timer state encoding and the status busy bit.
package usb_midi_pio_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  localparam int BUSY_BIT = 31;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/usb_midi_audio_synth_pio_pulse_if.sv
// Avalon-MM slave bus for the output PIO: word address, select, write strobe,
// write data and combinational read data.
interface usb_midi_audio_synth_pio_pulse_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/usb_midi_pio_pulse_timer.sv
// Pulse length timer: reloads on load, stops on abort, and flags the final
// cycle of a pulse so the register file can drop the pulsed lines.
module usb_midi_pio_pulse_timer
  import usb_midi_pio_pkg::*;
#(
  parameter int PULSE_CYCLES = 1000,
  parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             abort,
  output logic             expire,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  pulse_state_e     state;
  pulse_state_e     state_n;
  logic [CNT_W-1:0] count_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // A retrigger wins over the natural end of the pulse, and an abort wins over both.
  always_comb begin
    state_n = state;
    count_n = count;
    expire  = (state == PULSE) && (count == CNT_W'(1));
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
    end else if (load) begin
      state_n = PULSE;
      count_n = CNT_W'(PULSE_CYCLES);
    end else if (expire) begin
      state_n = IDLE;
      count_n = '0;
    end else if (state == PULSE) begin
      count_n = count - CNT_W'(1);
    end
  end

  assign busy = (state == PULSE);

endmodule

// File: rtl/usb_midi_audio_synth_pio_pulse.sv
// Avalon-MM output PIO with direct write, atomic set/clear and a
// hardware-timed pulse mode for exact-length strobes such as a USB reset.
module usb_midi_audio_synth_pio_pulse
  import usb_midi_pio_pkg::*;
#(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  usb_midi_audio_synth_pio_pulse_if.slave  bus,
  output logic [WIDTH-1:0]                 out_port
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] mask_n;
  logic [WIDTH-1:0] wd;
  logic             wr, data_wr, set_wr, clr_wr, pulse_wr;
  logic             expire, expire_eff, busy;
  logic [CNT_W-1:0] count;
  logic [31:0]      rd_data;
  logic             unused_wd_hi;

  assign wd           = bus.writedata[WIDTH-1:0];
  assign unused_wd_hi = ^bus.writedata[31:WIDTH];
  assign wr           = bus.chipselect && !bus.write_n;
  assign data_wr      = wr && (bus.address == ADDR_DATA);
  assign set_wr       = wr && (bus.address == ADDR_SET);
  assign clr_wr       = wr && (bus.address == ADDR_CLR);
  assign pulse_wr     = wr && (bus.address == ADDR_PULSE) && (wd != '0);
  assign expire_eff   = expire && !data_wr && !pulse_wr;

  usb_midi_pio_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (pulse_wr),
    .abort  (data_wr),
    .expire (expire),
    .busy   (busy),
    .count  (count)
  );

  // Expiry clear is applied first so a coincident SET/CLEAR has the final say.
  always_comb begin
    out_n  = out_port;
    mask_n = pulse_mask;
    if (expire_eff) begin
      out_n  = out_n & ~pulse_mask;
      mask_n = '0;
    end
    if (data_wr) begin
      out_n  = wd;
      mask_n = '0;
    end
    if (set_wr) begin
      out_n = out_n | wd;
    end
    if (clr_wr) begin
      out_n  = out_n & ~wd;
      mask_n = mask_n & ~wd;
    end
    if (pulse_wr) begin
      out_n  = out_n | wd;
      mask_n = mask_n | wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port   <= RESET_VALUE;
      pulse_mask <= '0;
    end else begin
      out_port   <= out_n;
      pulse_mask <= mask_n;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_DATA, ADDR_SET: rd_data[WIDTH-1:0] = out_port;
        ADDR_CLR:            rd_data[WIDTH-1:0] = pulse_mask;
        default: begin
          rd_data[BUSY_BIT]  = busy;
          rd_data[CNT_W-1:0] = count;
        end
      endcase
    end
  end

  assign bus.readdata = rd_data;

endmodule

// File: tb/tb_usb_midi_audio_synth_pio_pulse.sv
// Self-checking bench for the pulse PIO: directed scenarios plus random bus
// traffic compared against a deadline-based reference model.
module tb_usb_midi_audio_synth_pio_pulse;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b0001;
  localparam int         P  = 8;

  logic       clk;
  logic       reset;
  logic [3:0] out_port;

  usb_midi_audio_synth_pio_pulse_if bus ();

  usb_midi_audio_synth_pio_pulse #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lines, pulse lines, and the absolute edge at which the pulse ends.
  int         cyc = 0;
  logic [3:0] m_out;
  logic [3:0] m_mask;
  bit         m_busy;
  int         m_deadline;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void modelEdge(input bit rst, input bit cs, input bit we,
                                    input logic [1:0] a, input logic [31:0] d);
    logic [3:0] wd;
    bit wr, dw, pw;
    cyc++;
    if (rst) begin
      m_out  = RV;
      m_mask = '0;
      m_busy = 0;
      return;
    end
    wd = d[3:0];
    wr = cs && we;
    dw = wr && (a == 2'd0);
    pw = wr && (a == 2'd3) && (wd != 4'd0);
    if (m_busy && cyc == m_deadline && !dw && !pw) begin
      m_out  = m_out & ~m_mask;
      m_mask = '0;
      m_busy = 0;
    end
    if (wr) begin
      case (a)
        2'd0: begin m_out = wd; m_mask = '0; m_busy = 0; end
        2'd1: m_out = m_out | wd;
        2'd2: begin m_out = m_out & ~wd; m_mask = m_mask & ~wd; end
        default: if (pw) begin
          m_out      = m_out | wd;
          m_mask     = m_mask | wd;
          m_busy     = 1;
          m_deadline = cyc + P;
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0, 2'd1: return {28'b0, m_out};
      2'd2:       return {28'b0, m_mask};
      default:    return m_busy ? (32'h8000_0000 | 32'(m_deadline - cyc)) : 32'h0;
    endcase
  endfunction

  task automatic applyStimulus(input bit rst, input bit cs, input bit we,
                               input logic [1:0] a, input logic [31:0] d);
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = !we;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    modelEdge(rst, cs, we, a, d);
    #1;
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    checkOutput("out_port", {28'b0, out_port}, {28'b0, m_out});
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(0, 1, 1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic readValue(input logic [1:0] a, output logic [31:0] v);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic readCheck(input logic [1:0] a, input bit cs);
    logic [31:0] exp;
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = 1'b1;
    #1;
    exp = cs ? modelRead(a) : 32'h0;
    checkOutput($sformatf("read_a%0d_cs%0d", a, cs), bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  task automatic readAll();
    for (int a = 0; a < 4; a++) readCheck(2'(a), 1'b1);
  endtask

  initial begin
    logic [31:0] v;
    int hi;
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'h0;
    #2;

    // Reset state
    applyStimulus(1, 0, 0, 2'd0, 32'h0);
    applyStimulus(1, 0, 0, 2'd0, 32'h0);
    checkOutput("reset_out", {28'b0, out_port}, 32'h1);
    readValue(2'd3, v); checkOutput("reset_status", v, 32'h0);
    readValue(2'd2, v); checkOutput("reset_mask", v, 32'h0);

    // Direct, set and clear writes
    writeReg(2'd0, 32'hFFFF_FFFA); checkOutput("data_A", {28'b0, out_port}, 32'hA);
    writeReg(2'd1, 32'h1);         checkOutput("set_B", {28'b0, out_port}, 32'hB);
    writeReg(2'd2, 32'h8);         checkOutput("clr_3", {28'b0, out_port}, 32'h3);
    readValue(2'd0, v); checkOutput("read_data_3", v, 32'h3);
    readAll();

    // Single pulse: bit 2 high for exactly P cycles
    writeReg(2'd3, 32'h4);
    readValue(2'd3, v); checkOutput("status_k1", v, 32'h8000_0008);
    hi = out_port[2] ? 1 : 0;
    for (int i = 0; i < 20 && out_port[2]; i++) begin
      idle(1);
      readAll();
      if (out_port[2]) hi++;
    end
    checkOutput("pulse_width", 32'(hi), 32'(P));
    readValue(2'd3, v); checkOutput("status_done", v, 32'h0);

    // Retrigger at k+5
    writeReg(2'd0, 32'h0);
    writeReg(2'd3, 32'h4);
    idle(4);
    writeReg(2'd3, 32'h2);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      readValue(2'd3, v); checkOutput("retrig_busy", {31'b0, v[31]}, 32'h1);
    end
    checkOutput("retrig_hold", {28'b0, out_port}, 32'h6);
    idle(1);
    checkOutput("retrig_drop", {28'b0, out_port}, 32'h0);

    // DATA on expiry cycle
    writeReg(2'd3, 32'h4);
    idle(P - 1);
    writeReg(2'd0, 32'h4);
    checkOutput("coll_data_out", {28'b0, out_port}, 32'h4);
    readValue(2'd3, v); checkOutput("coll_data_busy", v, 32'h0);

    // SET on expiry cycle
    writeReg(2'd0, 32'h0);
    writeReg(2'd3, 32'h4);
    idle(P - 1);
    writeReg(2'd1, 32'h4);
    checkOutput("coll_set_out", {28'b0, out_port}, 32'h4);
    readAll();

    // CLEAR mid-pulse
    writeReg(2'd0, 32'h1);
    writeReg(2'd3, 32'h4);
    idle(2);
    writeReg(2'd2, 32'h4);
    checkOutput("coll_clr_out", {28'b0, out_port}, 32'h1);
    idle(P);
    checkOutput("coll_clr_after", {28'b0, out_port}, 32'h1);
    readAll();

    // Reset mid-pulse, then a zero pulse write
    writeReg(2'd0, 32'h0);
    writeReg(2'd3, 32'h4);
    idle(2);
    applyStimulus(1, 0, 0, 2'd0, 32'h0);
    checkOutput("midreset_out", {28'b0, out_port}, 32'h1);
    readValue(2'd3, v); checkOutput("midreset_status", v, 32'h0);
    writeReg(2'd3, 32'hFFFF_FFF0);
    checkOutput("pulse0_out", {28'b0, out_port}, 32'h1);
    readValue(2'd3, v); checkOutput("pulse0_status", v, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit rst, cs, we;
      logic [1:0] a;
      logic [31:0] d;
      rst = ($urandom_range(0, 99) < 2);
      cs  = ($urandom_range(0, 3) != 0);
      we  = ($urandom_range(0, 3) != 0);
      a   = 2'($urandom_range(0, 3));
      d   = $urandom;
      if ($urandom_range(0, 7) == 0) d[3:0] = 4'h0;
      applyStimulus(rst, cs, we, a, d);
      readCheck(2'($urandom_range(0, 3)), 1'b1);
      readCheck(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
